// File: rtl/fetch_stage_pkg.sv
// Shared types for the rv32i front end.
//   rv32i_type  : base word type used across the pipeline.
//   fetch_types : fetch FSM states, the fetched-instruction packet,
//                 the canonical NOP encoding and a word-alignment helper.
package rv32i_type;
   typedef logic [31:0] rv32i_word;
endpackage

package fetch_types;
   import rv32i_type::*;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      STALL = 2'd2,
      DROP  = 2'd3
   } fetch_state_t;

   typedef struct packed {
      rv32i_word instr;
      rv32i_word pc;
   } fetch_pkt_t;

   localparam rv32i_word RV32I_NOP = 32'h0000_0013;

   // Force an address onto a 4-byte boundary.
   function automatic rv32i_word word_align(input rv32i_word addr);
      return addr & 32'hFFFF_FFFC;
   endfunction
endpackage

// File: rtl/fetch_stage_buffer.sv
// fetch_buffer: one-entry register slice between instruction memory and decode.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture load_pkt and mark the slot valid
//   drain     : consumer took the current entry this cycle
//   flush     : discard the current entry (wrong path)
//   load_pkt  : instruction + PC to capture
//   valid     : slot holds an instruction
//   pkt       : held instruction + PC
// Priority is flush > load > drain, so a load in the same cycle as a drain
// overwrites the slot and keeps it valid.
module fetch_buffer
   import fetch_types::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       drain,
   input  logic       flush,
   input  fetch_pkt_t load_pkt,
   output logic       valid,
   output fetch_pkt_t pkt
);

   logic       valid_r;
   fetch_pkt_t pkt_r;

   // Slot occupancy and payload register.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r     <= 1'b0;
         pkt_r.instr <= 32'h0000_0000;
         pkt_r.pc    <= 32'h0000_0000;
      end else if (flush) begin
         valid_r <= 1'b0;
      end else if (load) begin
         valid_r <= 1'b1;
         pkt_r   <= load_pkt;
      end else if (drain) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign valid = valid_r;
   assign pkt   = pkt_r;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction-memory request FSM and the
// valid/ready producer side feeding decode_stage.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   imem_address  : word-aligned read address, stable while a request is open
//   imem_read     : read request, held until imem_resp
//   imem_rdata    : instruction data, valid with imem_resp
//   imem_resp     : one-cycle response strobe
//   redirect_i    : one-cycle flush/refetch pulse from a later stage
//   redirect_pc   : refetch target (low two bits ignored)
//   ready_i       : decode can accept this cycle
//   valid_o       : instruction/pc_o valid
//   instruction   : fetched instruction word
//   pc_o          : PC of instruction
module fetch_stage
   import rv32i_type::*;
   import fetch_types::*;
#(
   parameter rv32i_word RESET_PC = 32'h4000_0000
) (
   input  logic      clk,
   input  logic      rst,
   output rv32i_word imem_address,
   output logic      imem_read,
   input  rv32i_word imem_rdata,
   input  logic      imem_resp,
   input  logic      redirect_i,
   input  rv32i_word redirect_pc,
   input  logic      ready_i,
   output logic      valid_o,
   output rv32i_word instruction,
   output rv32i_word pc_o
);

   fetch_state_t state_r, state_next_s;
   rv32i_word    pc_r, pc_next_s;
   rv32i_word    addr_r;          // address of the open request
   logic         req_out_r;       // a request has been raised and awaits imem_resp
   logic         req_out_next_s;

   logic         buf_valid_s;
   fetch_pkt_t   buf_pkt_s;
   fetch_pkt_t   load_pkt_s;
   logic         drain_s;
   logic         buf_free_s;
   logic         issue_s;
   logic         accept_s;
   logic         flush_s;

   // A redirect kills the outgoing instruction in the same cycle.
   assign valid_o     = buf_valid_s & ~redirect_i;
   assign instruction = buf_pkt_s.instr;
   assign pc_o        = buf_pkt_s.pc;

   assign drain_s    = valid_o & ready_i;
   assign buf_free_s = ~buf_valid_s | drain_s;

   // A new request is only raised while the slot is empty or emptying, so
   // the response can never arrive into a full, stalled slot.
   assign issue_s  = (state_r == FETCH) & ~req_out_r & buf_free_s & ~redirect_i;
   assign accept_s = (state_r == FETCH) & req_out_r & imem_resp & ~redirect_i;
   assign flush_s  = redirect_i & (state_r != IDLE);

   assign imem_read    = req_out_r | issue_s;
   assign imem_address = req_out_r ? addr_r : pc_r;

   // Payload captured on an accepted response.
   always_comb begin
      load_pkt_s.instr = imem_rdata;
      load_pkt_s.pc    = pc_r;
   end

   fetch_buffer u_buffer (
      .clk      (clk),
      .rst      (rst),
      .load     (accept_s),
      .drain    (drain_s),
      .flush    (flush_s),
      .load_pkt (load_pkt_s),
      .valid    (buf_valid_s),
      .pkt      (buf_pkt_s)
   );

   // State, PC and open-request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         pc_r      <= RESET_PC;
         req_out_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         pc_r      <= pc_next_s;
         req_out_r <= req_out_next_s;
      end
   end

   // Latch the request address when it is first raised so DROP keeps the
   // old address on the bus even after the PC moves to a redirect target.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r <= RESET_PC;
      end else if (issue_s) begin
         addr_r <= pc_r;
      end else begin
         addr_r <= addr_r;
      end
   end

   // Next-state, next-PC and request bookkeeping.
   always_comb begin
      state_next_s   = state_r;
      pc_next_s      = pc_r;
      req_out_next_s = req_out_r;
      case (state_r)
         IDLE: begin
            state_next_s   = FETCH;
            req_out_next_s = 1'b0;
         end
         FETCH: begin
            if (redirect_i) begin
               pc_next_s = word_align(redirect_pc);
               if (req_out_r && !imem_resp) begin
                  state_next_s   = DROP;
                  req_out_next_s = 1'b1;
               end else begin
                  state_next_s   = FETCH;
                  req_out_next_s = 1'b0;
               end
            end else if (req_out_r) begin
               if (imem_resp) begin
                  pc_next_s      = pc_r + 32'd4;
                  state_next_s   = FETCH;
                  req_out_next_s = 1'b0;
               end else begin
                  state_next_s   = FETCH;
                  req_out_next_s = 1'b1;
               end
            end else if (buf_free_s) begin
               state_next_s   = FETCH;
               req_out_next_s = 1'b1;
            end else begin
               state_next_s   = STALL;
               req_out_next_s = 1'b0;
            end
         end
         STALL: begin
            req_out_next_s = 1'b0;
            if (redirect_i) begin
               pc_next_s    = word_align(redirect_pc);
               state_next_s = FETCH;
            end else if (drain_s) begin
               state_next_s = FETCH;
            end else begin
               state_next_s = STALL;
            end
         end
         DROP: begin
            if (redirect_i) begin
               pc_next_s = word_align(redirect_pc);
            end else begin
               pc_next_s = pc_r;
            end
            if (imem_resp) begin
               state_next_s   = FETCH;
               req_out_next_s = 1'b0;
            end else begin
               state_next_s   = DROP;
               req_out_next_s = 1'b1;
            end
         end
         default: begin
            state_next_s   = IDLE;
            pc_next_s      = pc_r;
            req_out_next_s = 1'b0;
         end
      endcase
   end

endmodule
